// File: rtl/dsp_pkg.sv
// dsp_pkg: carry-in select encodings and widths shared across the DSP slice.
package dsp_pkg;

   localparam int CISEL_W = 3;

   typedef logic [CISEL_W-1:0] cisel_t;

   localparam cisel_t CISEL_CARRYIN = 3'b000;
   localparam cisel_t CISEL_NPCIN   = 3'b001;
   localparam cisel_t CISEL_CASCIN  = 3'b010;
   localparam cisel_t CISEL_PCIN    = 3'b011;
   localparam cisel_t CISEL_CASCFB  = 3'b100;
   localparam cisel_t CISEL_NPMSB   = 3'b101;
   localparam cisel_t CISEL_MULT    = 3'b110;
   localparam cisel_t CISEL_PMSB    = 3'b111;

endpackage

// File: rtl/carry_pipe_reg.sv
// carry_pipe_reg: 1-bit carry flop (async clear, sync clear, enable) or wire-through bypass.
module carry_pipe_reg #(
   parameter bit REG = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rst_i,
   input  logic ce_i,
   input  logic d_i,
   output logic q_o
);

   generate
      if (REG) begin : g_reg
         logic q_q, q_d;
         // Sync clear wins over enable so a held carry can always be flushed.
         always_comb q_d = rst_i ? 1'b0 : ce_i ? d_i : q_q;
         always_ff @(posedge clk_i or negedge rst_ni)
            if (!rst_ni) q_q <= 1'b0;
            else         q_q <= q_d;
         assign q_o = q_q;
      end else begin : g_bypass
         logic unused;
         assign unused = ^{clk_i, rst_ni, rst_i, ce_i};
         assign q_o = d_i;
      end
   endgenerate

endmodule

// File: rtl/carry_in_logic.sv
// carry_in_logic: selects the ALU carry-in among eight sources, aligning CARRYIN and the
// multiply-rounding carry with their operand pipeline stages.
module carry_in_logic
   import dsp_pkg::*;
#(
   parameter bit CARRYINREG     = 1'b1,
   parameter bit MULTCARRYINREG = 1'b1
) (
   input  logic   CLK,
   input  logic   RST_N,
   input  logic   RSTALLCARRYIN,
   input  logic   CECARRYIN,
   input  logic   CEM,
   input  cisel_t CARRYINSEL,
   input  logic   CARRYIN,
   input  logic   CARRYCASCIN,
   input  logic   CARRYCASCOUT_FB,
   input  logic   PCIN_MSB,
   input  logic   P_MSB,
   input  logic   A_MSB,
   input  logic   B_MSB,
   output logic   CIN_ALU
);

   logic cin_path, mc, mc_path;

   // Rounding carry for symmetric rounding of the signed product.
   assign mc = ~(A_MSB ^ B_MSB);

   carry_pipe_reg #(.REG(CARRYINREG)) u_cin_reg (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .rst_i  (RSTALLCARRYIN),
      .ce_i   (CECARRYIN),
      .d_i    (CARRYIN),
      .q_o    (cin_path)
   );

   carry_pipe_reg #(.REG(MULTCARRYINREG)) u_mc_reg (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .rst_i  (RSTALLCARRYIN),
      .ce_i   (CEM),
      .d_i    (mc),
      .q_o    (mc_path)
   );

   always_comb begin
      case (CARRYINSEL)
         CISEL_NPCIN:  CIN_ALU = ~PCIN_MSB;
         CISEL_CASCIN: CIN_ALU = CARRYCASCIN;
         CISEL_PCIN:   CIN_ALU = PCIN_MSB;
         CISEL_CASCFB: CIN_ALU = CARRYCASCOUT_FB;
         CISEL_NPMSB:  CIN_ALU = ~P_MSB;
         CISEL_MULT:   CIN_ALU = mc_path;
         CISEL_PMSB:   CIN_ALU = P_MSB;
         default:      CIN_ALU = cin_path;
      endcase
   end

endmodule
